// File: rtl/xentry_pkg.sv
// Shared types for the L2 request arbiter: memory operation codes and arbiter FSM states.
package xentry_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } memory_operation_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  localparam logic GRANT_ICACHE = 1'b0;
  localparam logic GRANT_DCACHE = 1'b1;

endpackage

// File: rtl/arb_priority_select.sv
// Picks which cache port wins the shared L2 request slot.
// XENTRY_ARB_ROUND_ROBIN_EN selects round-robin ties; default is fixed dcache priority.
module arb_priority_select
  import xentry_pkg::*;
(
  input  logic icache_valid,
  input  logic dcache_valid,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

`ifdef XENTRY_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_valid = icache_valid | dcache_valid;
    grant_id    = dcache_valid ? GRANT_DCACHE : GRANT_ICACHE;
    // On a tie, hand the slot to whoever did not get it last time.
    if (icache_valid && dcache_valid) begin
      grant_id = ~last_grant;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = icache_valid | dcache_valid;
    grant_id    = dcache_valid ? GRANT_DCACHE : GRANT_ICACHE;
  end
`endif

endmodule

// File: rtl/l2_request_arbiter.sv
// Two-port (icache/dcache) to single L2 request arbiter with one outstanding transaction.
// Tie policy is set in arb_priority_select via XENTRY_ARB_ROUND_ROBIN_EN.
module l2_request_arbiter
  import xentry_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [XLEN-1:0]   icache_req_address,
  input  memory_operation_e icache_req_type,
  input  logic              icache_req_valid,
  output logic [XLEN-1:0]   icache_fetched_word,
  output logic              icache_req_fulfilled,

  input  logic [XLEN-1:0]   dcache_req_address,
  input  memory_operation_e dcache_req_type,
  input  logic              dcache_req_valid,
  input  logic [XLEN-1:0]   dcache_word_to_store,
  output logic [XLEN-1:0]   dcache_fetched_word,
  output logic              dcache_req_fulfilled,

  output logic [XLEN-1:0]   l2_req_address,
  output memory_operation_e l2_req_type,
  output logic              l2_req_valid,
  output logic [XLEN-1:0]   l2_word_to_store,
  input  logic [XLEN-1:0]   l2_fetched_word,
  input  logic              l2_req_fulfilled
);

  arb_state_e        state_q;
  logic              last_grant_q;
  logic [XLEN-1:0]   addr_q, addr_d;
  memory_operation_e type_q, type_d;
  logic [XLEN-1:0]   store_q, store_d;

  logic grant_valid;
  logic grant_id;

  arb_priority_select u_select (
    .icache_valid (icache_req_valid),
    .dcache_valid (dcache_req_valid),
    .last_grant   (last_grant_q),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  // Fields of the port that would be granted this cycle; icache never stores.
  always_comb begin
    addr_d  = icache_req_address;
    type_d  = icache_req_type;
    store_d = '0;
    if (grant_id == GRANT_DCACHE) begin
      addr_d  = dcache_req_address;
      type_d  = dcache_req_type;
      store_d = dcache_word_to_store;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_DCACHE;
      addr_q       <= '0;
      type_q       <= MEM_READ;
      store_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            last_grant_q <= grant_id;
            addr_q       <= addr_d;
            type_q       <= type_d;
            store_q      <= store_d;
            state_q      <= (grant_id == GRANT_DCACHE) ? SERVE_D : SERVE_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_req_fulfilled) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign l2_req_valid     = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign l2_req_address   = addr_q;
  assign l2_req_type      = type_q;
  assign l2_word_to_store = store_q;

  // Completion is routed straight through so the requester sees it in the same cycle.
  assign icache_req_fulfilled = (state_q == SERVE_I) && l2_req_fulfilled;
  assign dcache_req_fulfilled = (state_q == SERVE_D) && l2_req_fulfilled;
  assign icache_fetched_word  = (state_q == SERVE_I) ? l2_fetched_word : '0;
  assign dcache_fetched_word  = (state_q == SERVE_D) ? l2_fetched_word : '0;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed self-checking bench for l2_request_arbiter.
// Expected grant order follows XENTRY_ARB_ROUND_ROBIN_EN when it is defined.
module tb_l2_request_arbiter;
  import xentry_pkg::*;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [XLEN-1:0]   icache_req_address;
  memory_operation_e icache_req_type;
  logic              icache_req_valid;
  logic [XLEN-1:0]   icache_fetched_word;
  logic              icache_req_fulfilled;
  logic [XLEN-1:0]   dcache_req_address;
  memory_operation_e dcache_req_type;
  logic              dcache_req_valid;
  logic [XLEN-1:0]   dcache_word_to_store;
  logic [XLEN-1:0]   dcache_fetched_word;
  logic              dcache_req_fulfilled;
  logic [XLEN-1:0]   l2_req_address;
  memory_operation_e l2_req_type;
  logic              l2_req_valid;
  logic [XLEN-1:0]   l2_word_to_store;
  logic [XLEN-1:0]   l2_fetched_word;
  logic              l2_req_fulfilled;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_request_arbiter #(.XLEN(XLEN)) dut (
    .clk                  (clk),
    .reset                (reset),
    .icache_req_address   (icache_req_address),
    .icache_req_type      (icache_req_type),
    .icache_req_valid     (icache_req_valid),
    .icache_fetched_word  (icache_fetched_word),
    .icache_req_fulfilled (icache_req_fulfilled),
    .dcache_req_address   (dcache_req_address),
    .dcache_req_type      (dcache_req_type),
    .dcache_req_valid     (dcache_req_valid),
    .dcache_word_to_store (dcache_word_to_store),
    .dcache_fetched_word  (dcache_fetched_word),
    .dcache_req_fulfilled (dcache_req_fulfilled),
    .l2_req_address       (l2_req_address),
    .l2_req_type          (l2_req_type),
    .l2_req_valid         (l2_req_valid),
    .l2_word_to_store     (l2_word_to_store),
    .l2_fetched_word      (l2_fetched_word),
    .l2_req_fulfilled     (l2_req_fulfilled)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_port(input bit port);
    if (port) begin
      dcache_req_valid   = 1'b0;
      dcache_req_address = 32'hFFFF_FFFF;
    end else begin
      icache_req_valid   = 1'b0;
      icache_req_address = 32'hFFFF_FFFF;
    end
  endtask

  // One granted transaction: grant edge, `latency` busy cycles, fulfil, bubble.
  // drop_mode: 0 keep valid, 1 drop on the fulfil pulse, 2 drop right after grant.
  task automatic do_txn(input string tag, input bit port, input logic [31:0] addr,
                        input memory_operation_e typ, input logic [31:0] store,
                        input logic [31:0] rdata, input int latency, input int drop_mode);
    tick;
    check_eq({tag, ".valid"}, l2_req_valid, 1);
    check_eq({tag, ".addr"},  l2_req_address, addr);
    check_eq({tag, ".type"},  l2_req_type, typ);
    check_eq({tag, ".store"}, l2_word_to_store, store);
    if (drop_mode == 2) drop_port(port);
    for (int i = 0; i < latency; i++) begin
      tick;
      check_eq({tag, ".busy_valid"}, l2_req_valid, 1);
      check_eq({tag, ".busy_addr"},  l2_req_address, addr);
      check_eq({tag, ".busy_ful"},   {icache_req_fulfilled, dcache_req_fulfilled}, 0);
    end
    l2_fetched_word  = rdata;
    l2_req_fulfilled = 1'b1;
    #1;
    check_eq({tag, ".i_ful"},  icache_req_fulfilled, !port);
    check_eq({tag, ".d_ful"},  dcache_req_fulfilled, port);
    check_eq({tag, ".i_word"}, icache_fetched_word, port ? 32'h0 : rdata);
    check_eq({tag, ".d_word"}, dcache_fetched_word, port ? rdata : 32'h0);
    if (drop_mode == 1) drop_port(port);
    tick;
    check_eq({tag, ".bubble_valid"}, l2_req_valid, 0);
    check_eq({tag, ".bubble_ful"},   {icache_req_fulfilled, dcache_req_fulfilled}, 0);
    l2_req_fulfilled = 1'b0;
    l2_fetched_word  = '0;
    $display("txn %s port=%0d addr=0x%0h rdata=0x%0h", tag, port, addr, rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_seq[4];
`ifdef XENTRY_ARB_ROUND_ROBIN_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    reset                = 1'b0;
    icache_req_address   = 32'h0000_1000;
    icache_req_type      = MEM_READ;
    icache_req_valid     = 1'b1;
    dcache_req_address   = '0;
    dcache_req_type      = MEM_READ;
    dcache_req_valid     = 1'b0;
    dcache_word_to_store = '0;
    l2_fetched_word      = 32'hCAFE_F00D;
    l2_req_fulfilled     = 1'b1;

    // Reset state with noisy inputs
    #12;
    check_eq("rst.l2_valid", l2_req_valid, 0);
    check_eq("rst.ful",      {icache_req_fulfilled, dcache_req_fulfilled}, 0);
    check_eq("rst.i_word",   icache_fetched_word, 0);
    check_eq("rst.d_word",   dcache_fetched_word, 0);
    check_eq("rst.addr",     l2_req_address, 0);
    check_eq("rst.store",    l2_word_to_store, 0);
    icache_req_valid = 1'b0;
    l2_req_fulfilled = 1'b0;
    l2_fetched_word  = '0;
    @(negedge clk);
    reset = 1'b1;
    tick;
    check_eq("idle.l2_valid", l2_req_valid, 0);

    // Lone icache read
    icache_req_address = 32'h0000_1000;
    icache_req_type    = MEM_READ;
    icache_req_valid   = 1'b1;
    do_txn("t028", 1'b0, 32'h0000_1000, MEM_READ, 32'h0, 32'hDEAD_BEEF, 2, 1);

    // Downstream completion while idle is ignored
    l2_fetched_word  = 32'h5555_AAAA;
    l2_req_fulfilled = 1'b1;
    #1;
    check_eq("idle_ful.ful",    {icache_req_fulfilled, dcache_req_fulfilled}, 0);
    check_eq("idle_ful.i_word", icache_fetched_word, 0);
    check_eq("idle_ful.d_word", dcache_fetched_word, 0);
    tick;
    check_eq("idle_ful.l2_valid", l2_req_valid, 0);
    l2_req_fulfilled = 1'b0;
    l2_fetched_word  = '0;

    // Fresh reset, then simultaneous requests
    reset = 1'b0;
    #1;
    check_eq("rst2.addr", l2_req_address, 0);
    tick;
    reset = 1'b1;
    icache_req_address   = 32'h0000_0100;
    icache_req_type      = MEM_READ;
    icache_req_valid     = 1'b1;
    dcache_req_address   = 32'h0000_0200;
    dcache_req_type      = MEM_WRITE;
    dcache_word_to_store = 32'h1234_5678;
    dcache_req_valid     = 1'b1;
`ifdef XENTRY_ARB_ROUND_ROBIN_EN
    do_txn("t029_i", 1'b0, 32'h0000_0100, MEM_READ, 32'h0, 32'h1111_0001, 1, 1);
    do_txn("t029_d", 1'b1, 32'h0000_0200, MEM_WRITE, 32'h1234_5678, 32'h1111_0002, 1, 1);
`else
    do_txn("t029_d", 1'b1, 32'h0000_0200, MEM_WRITE, 32'h1234_5678, 32'h1111_0002, 1, 1);
    do_txn("t029_i", 1'b0, 32'h0000_0100, MEM_READ, 32'h0, 32'h1111_0001, 1, 1);
`endif

    // Both held valid across four transactions
    icache_req_address = 32'h0000_0100;
    icache_req_valid   = 1'b1;
    dcache_req_address = 32'h0000_0200;
    dcache_req_valid   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_txn($sformatf("t030_%0d", k), exp_seq[k],
             exp_seq[k] ? 32'h0000_0200 : 32'h0000_0100,
             exp_seq[k] ? MEM_WRITE : MEM_READ,
             exp_seq[k] ? 32'h1234_5678 : 32'h0,
             32'h2000_0000 + k, 1, 0);
    end
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    tick;
    check_eq("t030.idle_valid", l2_req_valid, 0);

    // Reset in the middle of a dcache transaction
    dcache_req_address   = 32'h0000_0300;
    dcache_req_type      = MEM_WRITE;
    dcache_word_to_store = 32'hA5A5_A5A5;
    dcache_req_valid     = 1'b1;
    tick;
    check_eq("t031.grant_valid", l2_req_valid, 1);
    tick;
    check_eq("t031.busy_valid", l2_req_valid, 1);
    reset = 1'b0;
    #1;
    check_eq("t031.rst_valid", l2_req_valid, 0);
    check_eq("t031.rst_addr",  l2_req_address, 0);
    check_eq("t031.rst_store", l2_word_to_store, 0);
    check_eq("t031.rst_dful",  dcache_req_fulfilled, 0);
    dcache_req_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    l2_fetched_word  = 32'h0BAD_0BAD;
    l2_req_fulfilled = 1'b1;
    #1;
    check_eq("t031.late_dful",  dcache_req_fulfilled, 0);
    check_eq("t031.late_dword", dcache_fetched_word, 0);
    tick;
    check_eq("t031.late_dful2", dcache_req_fulfilled, 0);
    check_eq("t031.late_valid", l2_req_valid, 0);
    l2_req_fulfilled = 1'b0;
    l2_fetched_word  = '0;
    $display("txn t031 reset mid-transaction, no completion issued");

    // Idle completion pulse with a pending request, then a dropped-valid transaction
    dcache_req_address   = 32'h0000_0400;
    dcache_req_type      = MEM_READ;
    dcache_word_to_store = 32'h0000_0077;
    dcache_req_valid     = 1'b1;
    l2_req_fulfilled     = 1'b1;
    #1;
    check_eq("t032.idle_dful", dcache_req_fulfilled, 0);
    l2_req_fulfilled = 1'b0;
    #1;
    do_txn("t032", 1'b1, 32'h0000_0400, MEM_READ, 32'h0000_0077, 32'h3333_4444, 3, 2);
    tick;
    check_eq("t032.after_valid", l2_req_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_request_arbiter.md
L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, 32, address/data width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: icache_req_address  input  XLEN; icache_req_type  input  memory_operation_e; icache_req_valid  input  1  icache request.
REQ-005 SHALL have ports: icache_fetched_word  output  XLEN; icache_req_fulfilled  output  1  icache response.
REQ-006 SHALL have ports: dcache_req_address  input  XLEN; dcache_req_type  input  memory_operation_e; dcache_req_valid  input  1; dcache_word_to_store  input  XLEN  dcache request.
REQ-007 SHALL have ports: dcache_fetched_word  output  XLEN; dcache_req_fulfilled  output  1  dcache response.
REQ-008 SHALL have ports: l2_req_address  output  XLEN; l2_req_type  output  memory_operation_e; l2_req_valid  output  1; l2_word_to_store  output  XLEN  shared downstream request.
REQ-009 SHALL have ports: l2_fetched_word  input  XLEN; l2_req_fulfilled  input  1  downstream response.

Function
REQ-010 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-011 IDLE: with any requester valid, SHALL grant one requester, capture its address/type/store-word into registers and move to SERVE_I or SERVE_D on that edge.
REQ-012 Request latency: requester valid sampled at edge N SHALL produce l2_req_valid=1 in cycle N+1.
REQ-013 l2_req_valid SHALL be 1 exactly in SERVE_I/SERVE_D; l2_req_address/type/store-word SHALL come from the capture registers and stay stable for the whole transaction.
REQ-014 For an icache grant, l2_word_to_store SHALL be 0.
REQ-015 SERVE_x: l2_req_fulfilled=1 SHALL pulse the granted port's *_req_fulfilled combinationally in the same cycle and return to IDLE on that edge.
REQ-016 *_fetched_word SHALL equal l2_fetched_word for the granted port and 0 otherwise; the non-granted *_req_fulfilled SHALL remain 0.
REQ-017 A requester sees at most one fulfilled pulse per grant; a new grant SHALL NOT occur before the IDLE cycle following fulfillment (one-cycle bubble).
REQ-018 l2_req_fulfilled while IDLE SHALL be ignored.
REQ-019 Requester dropping valid mid-transaction SHALL NOT abort; transaction completes and the fulfilled pulse is still issued.
REQ-020 Requesters hold valid and request fields until their fulfilled pulse; the arbiter SHALL NOT rely on fields after capture.
REQ-021 A last_grant register SHALL record the most recently granted port (0=icache, 1=dcache).

Reset
REQ-022 reset low SHALL immediately force FSM to IDLE, last_grant to 1 (icache wins first tie), capture registers to 0, and drive l2_req_valid, *_req_fulfilled, *_fetched_word, l2_req_address, l2_word_to_store to 0.
REQ-023 Reset asserted mid-transaction SHALL abandon it; no fulfilled pulse is issued for it afterwards.

Configuration
REQ-024 With XENTRY_ARB_ROUND_ROBIN_EN defined, simultaneous valid in IDLE SHALL grant the port not equal to last_grant.
REQ-025 Without XENTRY_ARB_ROUND_ROBIN_EN, simultaneous valid SHALL always grant dcache (fixed priority); last_grant still updates.

Structure
REQ-026 arb_state_e (IDLE, SERVE_I, SERVE_D) SHALL live in xentry_pkg next to memory_operation_e.
REQ-027 Grant selection SHALL be a combinational sub-module arb_priority_select (inputs: two valids, last_grant; output: grant_valid, grant_id), holding the macro-dependent logic.

Verification
REQ-028 Lone icache request addr 0x0000_1000: l2_req_valid next cycle, address 0x0000_1000, store-word 0; downstream fulfilled with 0xDEAD_BEEF -> icache_req_fulfilled pulse 1 cycle, icache_fetched_word 0xDEAD_BEEF, dcache outputs 0.
REQ-029 Simultaneous icache 0x100 and dcache store 0x200/0x1234_5678 after reset, round-robin build -> icache served first, then dcache after one IDLE bubble with l2_word_to_store 0x1234_5678.
REQ-030 Both held valid for 4 transactions, round-robin build -> grants I,D,I,D; fixed-priority build -> D,D,D,D, icache starved.
REQ-031 Reset low while SERVE_D with downstream busy -> l2_req_valid 0 same cycle; after release, late l2_req_fulfilled ignored, no dcache pulse.
REQ-032 l2_req_fulfilled pulsed in IDLE and dcache valid dropped mid-transaction -> no spurious pulses; dropped transaction still completes with exactly one dcache_req_fulfilled.
